// File: rtl/rs_dispatch_arbiter.sv
// Dispatch allocator from the IQ into the 14-entry RS array: picks a free slot per class, registers the grant.
// Optional RS_ARB_STATS_EN adds a saturating stall_cnt output.

module rs_alu_pair (
   input  logic [1:0] free,
   output logic       any_free,
   output logic       sel_hi
);
   assign any_free = |free;
   assign sel_hi   = !free[0];
endmodule

module rs_dispatch_arbiter #(
   parameter int NUM_ALU_UNITS = 5,
   parameter int PAY_W         = 64,
   localparam int NUM_SLOTS    = 2*NUM_ALU_UNITS + 4,
   localparam int SW           = $clog2(NUM_SLOTS),
   localparam int PW           = $clog2(NUM_ALU_UNITS)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 iq_req_valid,
   input  logic [1:0]           iq_req_class,
   input  logic [PAY_W-1:0]     iq_req_payload,
   output logic                 iq_req_ready,
   input  logic [NUM_SLOTS-1:0] rs_occ,
   input  logic                 flush,
   output logic                 load_rs,
   output logic [SW-1:0]        rs_sel,
   output logic [PAY_W-1:0]     rs_payload
`ifdef RS_ARB_STATS_EN
   ,
   output logic [15:0]          stall_cnt
`endif
);
   localparam logic [1:0] CLS_ALU = 2'd0, CLS_CMP = 2'd1, CLS_BR = 2'd2;
   localparam logic [SW-1:0] SLOT_CMP0 = SW'(2*NUM_ALU_UNITS);
   localparam logic [SW-1:0] SLOT_CMP1 = SW'(2*NUM_ALU_UNITS + 1);
   localparam logic [SW-1:0] SLOT_BR   = SW'(2*NUM_ALU_UNITS + 2);
   localparam logic [SW-1:0] SLOT_LDST = SW'(2*NUM_ALU_UNITS + 3);

   typedef struct packed {
      logic [SW-1:0]    sel;
      logic [PAY_W-1:0] payload;
   } grant_t;

   grant_t               out_q;
   logic                 out_valid;
   logic [PW-1:0]        rr_ptr;
   logic [NUM_SLOTS-1:0] inflight;
   logic [NUM_SLOTS-1:0] free;
   logic [NUM_ALU_UNITS-1:0] unit_free, unit_hi;
   logic                 alu_found, found, accept;
   logic [PW-1:0]        alu_unit;
   logic [SW-1:0]        alu_slot, slot;

   // The registered grant is not yet visible in rs_occ, so mask it here.
   always_comb begin
      inflight = '0;
      if (out_valid) inflight[out_q.sel] = 1'b1;
   end
   assign free = ~rs_occ & ~inflight;

   for (genvar u = 0; u < NUM_ALU_UNITS; u++) begin : g_pair
      rs_alu_pair u_pair (
         .free     (free[2*u+1:2*u]),
         .any_free (unit_free[u]),
         .sel_hi   (unit_hi[u])
      );
   end

   always_comb begin : alu_scan
      int u;
      u         = 0;
      alu_found = 1'b0;
      alu_unit  = '0;
      alu_slot  = '0;
      for (int i = 0; i < NUM_ALU_UNITS; i++) begin
         u = int'(rr_ptr) + i;
         if (u >= NUM_ALU_UNITS) u = u - NUM_ALU_UNITS;
         if (!alu_found && unit_free[u]) begin
            alu_found = 1'b1;
            alu_unit  = PW'(u);
            alu_slot  = SW'(2*u) + SW'(unit_hi[u]);
         end
      end
   end

   always_comb begin
      found = 1'b0;
      slot  = '0;
      case (iq_req_class)
         CLS_ALU: begin found = alu_found; slot = alu_slot; end
         CLS_CMP: begin
            found = free[SLOT_CMP0] | free[SLOT_CMP1];
            slot  = free[SLOT_CMP0] ? SLOT_CMP0 : SLOT_CMP1;
         end
         CLS_BR:  begin found = free[SLOT_BR];   slot = SLOT_BR;   end
         default: begin found = free[SLOT_LDST]; slot = SLOT_LDST; end
      endcase
   end

   assign iq_req_ready = rst && !flush && found;
   assign accept       = iq_req_valid && iq_req_ready;

   always_ff @(posedge clk) begin
      if (!rst) begin
         out_valid <= 1'b0;
         out_q     <= '0;
         rr_ptr    <= '0;
      end else begin
         out_valid <= accept;
         if (accept) begin
            out_q.sel     <= slot;
            out_q.payload <= iq_req_payload;
            if (iq_req_class == CLS_ALU)
               rr_ptr <= (alu_unit == PW'(NUM_ALU_UNITS-1)) ? '0 : alu_unit + PW'(1);
         end
      end
   end

   assign load_rs    = out_valid && !flush && rst;
   assign rs_sel     = out_q.sel;
   assign rs_payload = out_q.payload;

`ifdef RS_ARB_STATS_EN
   always_ff @(posedge clk) begin
      if (!rst)
         stall_cnt <= '0;
      else if (iq_req_valid && !iq_req_ready && !flush && stall_cnt != 16'hFFFF)
         stall_cnt <= stall_cnt + 16'd1;
   end
`endif
endmodule

// File: tb/tb_rs_dispatch_arbiter.sv
// Directed bench for rs_dispatch_arbiter: stimulus pushes hand-computed grants, a monitor pops on load_rs.
// Build with RS_ARB_STATS_EN to also cover stall_cnt.
module tb_rs_dispatch_arbiter;
   localparam logic [1:0] ALU = 2'd0, CMP = 2'd1, BR = 2'd2, LDST = 2'd3;

   logic        clk = 1'b0;
   logic        rst;
   logic        iq_req_valid;
   logic [1:0]  iq_req_class;
   logic [63:0] iq_req_payload;
   logic        iq_req_ready;
   logic [13:0] rs_occ;
   logic        flush;
   logic        load_rs;
   logic [3:0]  rs_sel;
   logic [63:0] rs_payload;
`ifdef RS_ARB_STATS_EN
   logic [15:0] stall_cnt;
`endif

   typedef struct {
      logic [3:0]  sel;
      logic [63:0] payload;
   } exp_t;
   exp_t sb[$];

   int checks = 0;
   int errors = 0;

   rs_dispatch_arbiter #(.NUM_ALU_UNITS(5), .PAY_W(64)) dut (
      .clk            (clk),
      .rst            (rst),
      .iq_req_valid   (iq_req_valid),
      .iq_req_class   (iq_req_class),
      .iq_req_payload (iq_req_payload),
      .iq_req_ready   (iq_req_ready),
      .rs_occ         (rs_occ),
      .flush          (flush),
      .load_rs        (load_rs),
      .rs_sel         (rs_sel),
      .rs_payload     (rs_payload)
`ifdef RS_ARB_STATS_EN
      ,
      .stall_cnt      (stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Monitor: every load_rs must match the oldest expected grant.
   always @(negedge clk) begin
      if (load_rs === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_load: got sel %0d payload %0h, expected no load", rs_sel, rs_payload);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("rs_sel", {60'd0, rs_sel}, {60'd0, e.sel});
            chk("rs_payload", rs_payload, e.payload);
         end
      end
   end

   // One cycle of stimulus; inputs change 1 unit after posedge, ready checked at negedge.
   task automatic step(input logic v, input logic [1:0] c, input logic [63:0] p,
                       input logic [13:0] occ, input logic fl,
                       input logic exp_rdy, input logic [3:0] exp_sel, input logic push);
      iq_req_valid = v; iq_req_class = c; iq_req_payload = p; rs_occ = occ; flush = fl;
      @(negedge clk);
      chk("iq_req_ready", {63'd0, iq_req_ready}, {63'd0, exp_rdy});
      if (v && exp_rdy && push) sb.push_back('{exp_sel, p});
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         iq_req_valid = 1'b0; rs_occ = '0; flush = 1'b0;
         @(posedge clk); #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; iq_req_valid = 1'b1; iq_req_class = ALU; iq_req_payload = 64'hDEAD;
      rs_occ = '0; flush = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_ready", {63'd0, iq_req_ready}, 64'd0);
      chk("rst_load", {63'd0, load_rs}, 64'd0);
      chk("rst_sel", {60'd0, rs_sel}, 64'd0);
      chk("rst_payload", rs_payload, 64'd0);
`ifdef RS_ARB_STATS_EN
      chk("rst_stall_cnt", {48'd0, stall_cnt}, 64'd0);
`endif
      @(posedge clk); #1;
      rst = 1'b1;

      // Round robin over five ALU units, all free.
      step(1, ALU, 64'd1, 14'h0, 0, 1, 4'd0, 1);
      step(1, ALU, 64'd2, 14'h0, 0, 1, 4'd2, 1);
      step(1, ALU, 64'd3, 14'h0, 0, 1, 4'd4, 1);
      step(1, ALU, 64'd4, 14'h0, 0, 1, 4'd6, 1);
      step(1, ALU, 64'd5, 14'h0, 0, 1, 4'd8, 1);
      idle(2);

      // rr_ptr back at 0; slot 0 busy picks 1, then unit 1.
      step(1, ALU, 64'h11, 14'h0001, 0, 1, 4'd1, 1);
      step(1, ALU, 64'h12, 14'h0003, 0, 1, 4'd2, 1);
      idle(2);

      // Back-to-back BR: in-flight mask, then RS holds 12, then releases it.
      step(1, BR, 64'h21, 14'h0000, 0, 1, 4'd12, 1);
      step(1, BR, 64'h22, 14'h0000, 0, 0, 4'd0, 1);
      step(1, BR, 64'h22, 14'h1000, 0, 0, 4'd0, 1);
      step(1, BR, 64'h22, 14'h1000, 0, 0, 4'd0, 1);
      step(1, BR, 64'h22, 14'h0000, 0, 1, 4'd12, 1);
      idle(2);

      // Everything occupied: no class can be accepted.
      step(1, ALU,  64'h31, 14'h3FFF, 0, 0, 4'd0, 1);
      step(1, CMP,  64'h32, 14'h3FFF, 0, 0, 4'd0, 1);
      step(1, BR,   64'h33, 14'h3FFF, 0, 0, 4'd0, 1);
      step(1, LDST, 64'h34, 14'h3FFF, 0, 0, 4'd0, 1);
      iq_req_valid = 1'b0; rs_occ = '0;
      @(negedge clk);
`ifdef RS_ARB_STATS_EN
      chk("stall_cnt", {48'd0, stall_cnt}, 64'd7);
`endif
      @(posedge clk); #1;
      idle(1);

      // CMP grant killed by flush in the following cycle; slot 10 stays free.
      step(1, CMP, 64'h51, 14'h0, 0, 1, 4'd10, 0);
      iq_req_valid = 1'b1; iq_req_class = CMP; iq_req_payload = 64'h52; flush = 1'b1;
      @(negedge clk);
      chk("flush_load", {63'd0, load_rs}, 64'd0);
      chk("flush_ready", {63'd0, iq_req_ready}, 64'd0);
      @(posedge clk); #1;
      step(1, CMP, 64'h53, 14'h0, 0, 1, 4'd10, 1);
      idle(2);

      // Reset lands on an in-flight LDST grant.
      step(1, LDST, 64'h61, 14'h0, 0, 1, 4'd13, 0);
      rst = 1'b0; iq_req_valid = 1'b0;
      @(negedge clk);
      chk("midrst_load", {63'd0, load_rs}, 64'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("midrst_load2", {63'd0, load_rs}, 64'd0);
      chk("midrst_sel", {60'd0, rs_sel}, 64'd0);
      chk("midrst_payload", rs_payload, 64'd0);
`ifdef RS_ARB_STATS_EN
      chk("midrst_stall_cnt", {48'd0, stall_cnt}, 64'd0);
`endif
      @(posedge clk); #1;
      rst = 1'b1;
      step(1, LDST, 64'h62, 14'h0, 0, 1, 4'd13, 1);
      idle(3);

      chk("scoreboard_drained", 64'(sb.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/rs_dispatch_arbiter.md
# rs_dispatch_arbiter

Allocation controller between the instruction queue and the 14-entry reservation-station array. Accepts one dispatch request per cycle with a valid/ready handshake and picks a free RS slot for it. ALU-class requests are spread across the five ALU unit pairs with a round-robin pointer; CMP, BR and LD/ST requests are steered to their dedicated slots. It drives the RS load strobe, slot select and payload from a registered output stage, and masks in-flight slots so no slot is ever double-allocated.

## Interface
- NUM_ALU_UNITS, 5, ALU unit pairs; slots 2u/2u+1 for u in 0..4
- PAY_W, 64, opaque dispatch payload width (dest_rob, ops, srcs), passed through untouched
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- iq_req_valid  in  1  IQ has a dispatch request
- iq_req_class  in  2  0=ALU, 1=CMP (slots 10/11), 2=BR (slot 12), 3=LDST (slot 13)
- iq_req_payload  in  PAY_W  request payload
- iq_req_ready  out  1  request accepted this cycle when high together with valid
- rs_occ  in  14  per-slot RS valid bits; bit s = res_st[s].valid
- flush  in  1  mispredict/kill; drops the held request
- load_rs  out  1  one-cycle RS write strobe
- rs_sel  out  4  target slot 0..13
- rs_payload  out  PAY_W  payload for the selected slot

## Operation
- free[s] = !rs_occ[s] && !(out_valid && out_sel==s).
- ALU class: scan units starting at rr_ptr, in order rr_ptr, rr_ptr+1, … mod 5. The first unit with a free slot wins. Within a unit, slot 2u beats 2u+1.
- CMP class: slot 10 if free, else 11. BR class: slot 12 if free. LDST class: slot 13 if free.
- iq_req_ready = rst && !flush && (a free slot exists for iq_req_class). It is combinational from the current-cycle inputs and state.
- On accept (valid && ready), at the clock edge:
  - out_valid<=1, out_sel<=chosen slot, out_payload<=iq_req_payload.
  - If ALU class, rr_ptr <= (granted unit+1) mod 5.
- Without an accept, at the clock edge: out_valid<=0, and out_sel/out_payload hold their values.
- Outputs: load_rs = out_valid && !flush; rs_sel = out_sel; rs_payload = out_payload.
- Non-accepted requests and non-ALU grants leave rr_ptr unchanged.
- flush high: iq_req_ready=0, load_rs=0, out_valid<=0 at the edge, rr_ptr unchanged.
- A slot that the RS evicts this cycle still reads occupied. It becomes eligible the cycle after rs_occ drops.
- Reset (rst==0 at an edge): out_valid=0, out_sel=0, out_payload=0, rr_ptr=0, stall counter=0. While rst is low, iq_req_ready=0 and load_rs=0. Reset asserted mid-stream discards any held request.

## Timing
- Accept in cycle N → load_rs=1 with rs_sel/rs_payload valid in cycle N+1.
- The RS latches at the end of N+1, and rs_occ reflects the slot from N+2 onward.
- The in-flight mask covers the N+1 gap. Throughput is one dispatch per cycle with back-to-back accepts.
- load_rs is high for exactly one cycle per accepted, non-flushed request.
- No combinational path from rs_occ to load_rs. The only path from rs_occ is to iq_req_ready.

## Configuration
- RS_ARB_STATS_EN defined: adds output stall_cnt (16 bits).
  - Increments when iq_req_valid && !iq_req_ready && !flush && rst.
  - Saturates at 0xFFFF and resets to 0.
- Undefined: no stall_cnt port, no counter logic; all other behaviour identical.

## Test plan
- Reset then all free; 5 consecutive ALU requests (payload 1..5) → rs_sel 0,2,4,6,8 in cycles 1..5 after acceptance, payload matching, rr_ptr back to 0.
- rs_occ=0x0001 (slot 0 busy), rr_ptr=0, ALU request → rs_sel=1. Then rs_occ=0x0003 → next ALU request gets rs_sel=2.
- Two back-to-back BR requests, rs_occ all 0 → first granted slot 12. Second has iq_req_ready=0 (in-flight mask) until rs_occ[12] drops, then is granted 12.
- rs_occ=0x3FFF with every class requested → iq_req_ready=0 every cycle. With RS_ARB_STATS_EN, stall_cnt increments by 1 per cycle.
- CMP request accepted in cycle N, flush=1 in N+1 → load_rs stays 0, slot 10 is not written, and the next CMP request is granted slot 10.
- rst driven low during an in-flight LDST grant → load_rs=0 the same cycle and all outputs are 0 after the edge. After release, a LDST request is accepted and gets rs_sel=13.
